// File: rtl/dmem_ctrl.sv
// Word-addressed data memory with a fixed, parameterised access latency and a
// single-cycle ack pulse; out-of-range accesses complete normally but raise err_o.
module dmem_ctrl #(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int DEPTH          = 256,
    parameter int LATENCY        = 2
) (
    input  logic                      clk_i,
    input  logic                      arst_ni,
    input  logic                      dmem_req_i,
    input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
    input  logic                      dmem_we_i,
    input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
    output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
    output logic                      dmem_ack_o,
    output logic                      busy_o,
    output logic                      err_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $fatal(1, "dmem_ctrl: LATENCY must be in 1..15");
        end
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || IDX_W > MEM_ADDR_WIDTH) begin : g_bad_depth
            $fatal(1, "dmem_ctrl: DEPTH must be a power of 2 that fits the address bus");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [3:0]                r_cnt;
    logic [3:0]                w_cnt_nxt;
    logic                      w_capture;
    logic                      w_enter_resp;

    logic [MEM_ADDR_WIDTH-1:0] r_addr;
    logic                      r_we;
    logic [MEM_DATA_WIDTH-1:0] r_wdata;
    logic [MEM_DATA_WIDTH-1:0] r_rdata;
    logic                      r_err;
    logic [MEM_DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [MEM_ADDR_WIDTH-1:0] w_op_addr;
    logic                      w_op_we;
    logic [MEM_DATA_WIDTH-1:0] w_op_wdata;
    logic                      w_oor;
    logic [IDX_W-1:0]          w_idx;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_capture    = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dmem_req_i) begin
                    w_capture = 1'b1;
                    w_cnt_nxt = CNT_INIT;
                    if (LATENCY == 1) begin
                        w_state_nxt  = S_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = S_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // With LATENCY==1 the access completes on its capture edge, so it must use the live inputs.
    assign w_op_addr  = (r_state == S_IDLE) ? dmem_addr_i  : r_addr;
    assign w_op_we    = (r_state == S_IDLE) ? dmem_we_i    : r_we;
    assign w_op_wdata = (r_state == S_IDLE) ? dmem_wdata_i : r_wdata;
    assign w_idx      = w_op_addr[IDX_W-1:0];

    generate
        if (MEM_ADDR_WIDTH > IDX_W) begin : g_range_chk
            assign w_oor = |w_op_addr[MEM_ADDR_WIDTH-1:IDX_W];
        end else begin : g_no_range_chk
            assign w_oor = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_capture) begin
                r_addr  <= dmem_addr_i;
                r_we    <= dmem_we_i;
                r_wdata <= dmem_wdata_i;
            end
            if (w_enter_resp) begin
                r_err <= w_oor;
                if (!w_op_we) begin
                    r_rdata <= w_oor ? '0 : r_mem[w_idx];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enter_resp && w_op_we && !w_oor) begin
            r_mem[w_idx] <= w_op_wdata;
        end
    end

    assign dmem_rdata_o = r_rdata;
    assign dmem_ack_o   = (r_state == S_RESP);
    assign err_o        = (r_state == S_RESP) && r_err;
    assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a timestamp-based transaction model predicts ack/busy/err/rdata
// every cycle, while directed scenarios pin literal values and handshake timing.
module tb_dmem_ctrl #(
    parameter int TB_LATENCY = 2
);
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          we = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          ack;
    logic          busy;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    dmem_ctrl #(
        .MEM_ADDR_WIDTH(AW),
        .MEM_DATA_WIDTH(DW),
        .DEPTH(DEPTH),
        .LATENCY(TB_LATENCY)
    ) dut (
        .clk_i(clk),
        .arst_ni(arst_n),
        .dmem_req_i(req),
        .dmem_addr_i(addr),
        .dmem_we_i(we),
        .dmem_wdata_i(wdata),
        .dmem_rdata_o(rdata),
        .dmem_ack_o(ack),
        .busy_o(busy),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an access captured at edge c completes at edge c+L-1; the
    // next capture is possible from edge c+L+1.
    logic [DW-1:0] mem_m [DEPTH];
    int            edge_n = 0;
    int            cap_edge = 0;
    int            next_free = 0;
    bit            pending = 0;
    logic          cap_we = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wd = '0;
    logic          exp_ack = 1'b0;
    logic          exp_busy = 1'b0;
    logic          exp_err = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end

    always @(posedge clk) begin
        edge_n++;
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            pending   = 0;
            next_free = 0;
            exp_ack   = 1'b0;
            exp_busy  = 1'b0;
            exp_err   = 1'b0;
            exp_rdata = '0;
        end else begin
            exp_ack = 1'b0;
            exp_err = 1'b0;
            if (!pending && edge_n >= next_free && req) begin
                pending  = 1;
                cap_edge = edge_n;
                cap_we   = we;
                cap_addr = addr;
                cap_wd   = wdata;
            end
            if (pending && edge_n == cap_edge + TB_LATENCY - 1) begin
                if (cap_addr >= AW'(DEPTH)) begin
                    exp_err = 1'b1;
                    if (!cap_we) exp_rdata = '0;
                end else if (cap_we) begin
                    mem_m[cap_addr] = cap_wd;
                end else begin
                    exp_rdata = mem_m[cap_addr];
                end
                exp_ack   = 1'b1;
                pending   = 0;
                next_free = cap_edge + TB_LATENCY + 1;
            end
            exp_busy = pending || exp_ack;
        end
    end

    always @(negedge clk) begin
        check_eq("model_ack", 32'(ack), 32'(exp_ack));
        check_eq("model_busy", 32'(busy), 32'(exp_busy));
        check_eq("model_err", 32'(err), 32'(exp_err));
        check_eq("model_rdata", rdata, exp_rdata);
    end

    // One access from idle; lat counts edges from capture until ack is visible.
    task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit scramble, output logic [DW-1:0] rd, output logic er);
        int lat;
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req = 1'b0;
        while (!ack && lat < 40) begin
            if (scramble) begin
                req = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
                addr = $urandom_range(0, 255); wdata = $urandom;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check_eq("ack_latency", 32'(lat), 32'(TB_LATENCY));
        rd = rdata;
        er = err;
        @(posedge clk);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          er;
        int            ack_cnt;
        bit            prev_ack;
        bit            dbl_ack;

        repeat (2) @(negedge clk);
        check_eq("reset_ack", 32'(ack), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_rdata", rdata, 32'd0);
        #2 arst_n = 1'b1;

        // Write then read back
        access(1'b1, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check_eq("s1_wr_err", 32'(er), 32'd0);
        check_eq("s1_model_mem", mem_m[16], 32'hDEADBEEF);
        access(1'b0, 32'h10, 32'h0, 0, rd, er);
        check_eq("s1_rd_data", rd, 32'hDEADBEEF);
        check_eq("s1_rd_err", 32'(er), 32'd0);

        // Held request, alternating we and address
        ack_cnt = 0; prev_ack = 0; dbl_ack = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 32'h20; wdata = $urandom;
        for (int k = 1; k <= 20 * (TB_LATENCY + 1); k++) begin
            @(negedge clk);
            if (ack) begin
                ack_cnt++;
                if (prev_ack) dbl_ack = 1;
            end
            prev_ack = ack;
            req   = (k < 20 * (TB_LATENCY + 1));
            we    = k[0];
            addr  = k[1] ? 32'h21 : 32'h20;
            wdata = $urandom;
        end
        check_eq("s2_ack_count", 32'(ack_cnt), 32'd20);
        check_eq("s2_double_ack", 32'(dbl_ack), 32'd0);

        // Out-of-range accesses
        access(1'b0, 32'h100, 32'h0, 0, rd, er);
        check_eq("s3_rd_err", 32'(er), 32'd1);
        check_eq("s3_rd_data", rd, 32'd0);
        access(1'b1, 32'h100, 32'h55, 0, rd, er);
        check_eq("s3_wr_err", 32'(er), 32'd1);
        access(1'b0, 32'h0, 32'h0, 0, rd, er);
        check_eq("s3_mem0", rd, 32'd0);

        // Inputs disturbed while the access is in flight
        access(1'b1, 32'h05, 32'h1234, 1, rd, er);
        access(1'b0, 32'h05, 32'h0, 0, rd, er);
        check_eq("s4_rd_data", rd, 32'h1234);
        access(1'b0, 32'h06, 32'h0, 0, rd, er);
        check_eq("s4_neighbour", rd, 32'd0);

        // Reset while a write is outstanding
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h07; wdata = 32'hAA;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #2 arst_n = 1'b0;
        @(negedge clk);
        check_eq("s5_ack", 32'(ack), 32'd0);
        check_eq("s5_busy", 32'(busy), 32'd0);
        @(negedge clk);
        #2 arst_n = 1'b1;
        access(1'b0, 32'h07, 32'h0, 0, rd, er);
        check_eq("s5_rd_data", rd, 32'd0);
        access(1'b0, 32'h10, 32'h0, 0, rd, er);
        check_eq("s5_cleared", rd, 32'd0);

        // Random traffic with one asynchronous reset in the middle
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            req   = ($urandom_range(0, 3) != 0);
            we    = 1'($urandom_range(0, 1));
            addr  = $urandom_range(0, DEPTH + 15);
            wdata = $urandom;
            if (k == 300) #2 arst_n = 1'b0;
            if (k == 303) #2 arst_n = 1'b1;
        end
        @(negedge clk);
        req = 1'b0;
        repeat (TB_LATENCY + 3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
